// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: state encoding and constants shared by the fetch stage.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_WAIT,
      FETCH_HOLD,
      FETCH_DROP
   } fetch_state_t;

   localparam int BUBBLE_WORD = 0;
   localparam int PC_STEP     = 4;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: single-entry word/pc buffer that keeps a returned word while fetch is stalled.
module fetch_hold_buf
   import fetch_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] load_word,
   input  logic [ADDR_WIDTH-1:0] load_pc,
   output logic [DATA_WIDTH-1:0] word,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  valid
);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         word  <= DATA_WIDTH'(BUBBLE_WORD);
         pc    <= '0;
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         word  <= load_word;
         pc    <= load_pc;
         valid <= 1'b1;
      end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, the imem handshake and the IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a fetch exception instead of a request.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  branch,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic                  inst_valid,
   output logic                  inst_except
);

   fetch_state_t          state, state_n;
   logic [ADDR_WIDTH-1:0] pc, pc_n, tgt, word_pc, buf_pc;
   logic [DATA_WIDTH-1:0] word, buf_word;
   logic                  misalign, retarget, consume, fault, fault_n, buf_valid, buf_load;

`ifdef FETCH_ALIGN_CHECK_EN
   assign tgt      = branch_target;
   assign misalign = branch_target[1:0] != 2'b00;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) fault <= 1'b0;
      else fault <= fault_n;
`else
   assign tgt      = branch_target & ~ADDR_WIDTH'(3);
   assign misalign = 1'b0;
   assign fault    = 1'b0;
`endif

   assign retarget = branch && (tgt != pc);
   assign buf_load = state == FETCH_WAIT && mem_ack && stall && !retarget;

   fetch_hold_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (buf_load),
      .clear     (consume || retarget),
      .load_word (mem_rdata),
      .load_pc   (pc),
      .word      (buf_word),
      .pc        (buf_pc),
      .valid     (buf_valid)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= FETCH_IDLE;
      else state <= state_n;

   // A redirect in WAIT leaves the old request outstanding, so it is drained in DROP.
   always_comb begin
      state_n = state;
      case (state)
         FETCH_IDLE: state_n = retarget && misalign ? FETCH_HOLD : FETCH_WAIT;
         FETCH_WAIT: state_n = retarget ? (!mem_ack ? FETCH_DROP : misalign ? FETCH_HOLD : FETCH_WAIT)
                                        : (mem_ack && stall ? FETCH_HOLD : FETCH_WAIT);
         FETCH_HOLD: state_n = retarget ? (misalign ? FETCH_HOLD : FETCH_WAIT)
                                        : (consume && !fault ? FETCH_WAIT : FETCH_HOLD);
         FETCH_DROP: state_n = !mem_ack ? FETCH_DROP : fault_n ? FETCH_HOLD : FETCH_WAIT;
      endcase
   end

   always_comb begin
      done    = ((state == FETCH_WAIT && mem_ack) || state == FETCH_HOLD) && !retarget;
      consume = done && !stall;
      fault_n = retarget ? misalign : fault;
      word    = fault ? DATA_WIDTH'(BUBBLE_WORD) : buf_valid ? buf_word : mem_rdata;
      word_pc = buf_valid ? buf_pc : pc;
      pc_n    = retarget ? tgt : consume && !fault ? pc + ADDR_WIDTH'(PC_STEP) : pc;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc          <= RESET_ADDR;
         mem_req     <= 1'b0;
         mem_addr    <= RESET_ADDR;
         inst        <= DATA_WIDTH'(BUBBLE_WORD);
         inst_pc     <= '0;
         inst_valid  <= 1'b0;
         inst_except <= 1'b0;
      end else begin
         pc      <= pc_n;
         mem_req <= state_n == FETCH_WAIT || state_n == FETCH_DROP;
         if (state_n == FETCH_WAIT) mem_addr <= pc_n;
         if (flush) begin
            inst        <= DATA_WIDTH'(BUBBLE_WORD);
            inst_valid  <= 1'b0;
            inst_except <= 1'b0;
         end else if (consume) begin
            inst        <= word;
            inst_pc     <= word_pc;
            inst_valid  <= 1'b1;
            inst_except <= fault;
         end
      end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; the responder side of the pipeline controller's fetch interface.
- Consumes the controller's stall, flush and redirect (branch/target) signals and produces the fetch-done feedback.
- Owns the PC and the instruction-memory request handshake, buffers a returned word while stalled, and drops stale responses after a redirect.
- Feeds the IF/ID register (inst, inst_pc, inst_valid) read by decode.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC / memory address width.
- RESET_ADDR, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall  input  1  fetch_stall from the controller; hold the PC and the output register.
- flush  input  1  fetch_flush from the controller; load a bubble into the output register.
- branch  input  1  fetch_branch; redirect request, level, may be held several cycles.
- branch_target  input  ADDR_WIDTH  redirect PC.
- mem_req  output  1  instruction-memory request, registered.
- mem_addr  output  ADDR_WIDTH  request address; stable while mem_req=1.
- mem_ack  input  1  one-cycle response strobe, at least 1 cycle after mem_req rises.
- mem_rdata  input  DATA_WIDTH  instruction word, valid with mem_ack.
- done  output  1  fetch_done; the word for the current PC is available this cycle.
- inst  output  DATA_WIDTH  IF/ID instruction.
- inst_pc  output  ADDR_WIDTH  IF/ID PC.
- inst_valid  output  1  IF/ID valid (0 = bubble).
- inst_except  output  1  IF/ID fetch-exception flag (see Optional Feature).

Behaviour:
- Reset values: state=IDLE, pc=RESET_ADDR, mem_req=0, mem_addr=RESET_ADDR, done=0, inst=0, inst_pc=0, inst_valid=0, inst_except=0, hold buffer empty. Reset may arrive mid-request; an ack arriving after reset is ignored.
- States:
  - IDLE: issue a request for pc next cycle, go to WAIT.
  - WAIT: mem_req=1 with mem_addr=pc until mem_ack.
  - HOLD: word buffered, mem_req=0.
  - DROP: stale request outstanding; wait for mem_ack, discard it, then go to WAIT for the new pc.
- done:
  - Combinational: (WAIT && mem_ack) || HOLD.
  - Forced 0 in the cycle a retargeting redirect is applied.
- Consume = done && !stall && !retarget.
  - On consume: inst<=word, inst_pc<=pc, inst_valid<=1, pc<=pc+4, next state WAIT with mem_addr=pc+4.
  - Issue-to-issue minimum is therefore 2 cycles.
- WAIT && mem_ack && stall: the word is latched into the hold buffer and the state moves to HOLD. done stays 1 until consume or retarget.
- Retarget = branch && (branch_target != pc).
  - pc<=branch_target.
  - WAIT goes to DROP.
  - HOLD/IDLE go to WAIT for the new target; the hold buffer is cleared.
  - DROP stays DROP; the new target is used on reissue.
- branch with branch_target == pc: no action. A held redirect therefore converges and lets the controller clear its pending load.
- Simultaneous mem_ack and retarget in WAIT: the word is discarded and the state goes straight to WAIT at the new target (not DROP).
- flush (priority over stall): inst_valid<=0, inst<=0, inst_except<=0; inst_pc unchanged. pc advances only if consume also holds.
- stall && !flush: the output register holds.
- PC arithmetic: pc+4 modulo 2^ADDR_WIDTH; 'hFFFF_FFFC wraps to 0.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- With the macro defined, a retarget where branch_target[1:0]!=0:
  - issues no memory request and enters HOLD directly;
  - done=1 from the next cycle;
  - on consume: inst=0, inst_valid=1, inst_except=1, and the PC is not advanced until a further redirect.
- Without the macro: target bits [1:0] are forced to 0 and inst_except is tied to 0.

Decomposition:
- Shared package/defines:
  - state encoding FETCH_IDLE/WAIT/HOLD/DROP;
  - the NOP/bubble word constant;
  - PC_STEP=4.
- One sub-module, fetch_hold_buf: a single-entry word/pc buffer with load/clear/valid.

Test Plan:
1. Reset with RESET_ADDR=0: one idle cycle, then mem_req=1, mem_addr=0. Ack 2 cycles later with 32'h2402_0001 → done=1 that cycle; next edge inst=32'h2402_0001, inst_pc=0, inst_valid=1, mem_addr=4.
2. stall=1 when ack for 0x8 arrives → HOLD, done stays 1, mem_req=0. stall drops 3 cycles later → inst loads, inst_pc=8, next request at 0xC.
3. Request at 0x10 pending; branch=1 with target 0x100 held 4 cycles → DROP. Ack for 0x10 is discarded, no inst_valid for 0x10, next request 0x100, done=1 on its ack.
4. branch with target 0x200 in the same cycle as ack for 0x14 → word dropped, mem_addr=0x200 next cycle.
5. flush=1 and stall=1 for 2 cycles → inst_valid=0 while pc holds. The fetch of pc+4 = 0xFFFF_FFFC+4 wraps to mem_addr=0.
6. FETCH_ALIGN_CHECK_EN: branch to 0x102 → no mem_req, inst_except=1, inst_valid=1 on consume. Macro off: request goes to 0x100.
